reg_file_2r1w: RTL and testbench
================================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits, a multiple of 8 with minimum 8.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries, range 2..256.
REQ-003 The block SHALL have parameter ADDR_W, default 3, address width, which SHALL be at least clog2(DEPTH).
REQ-004 The block SHALL have port CLK, input, 1 bit: clock; all state updates on rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port WrEn, input, 1 bit: write request.
REQ-007 The block SHALL have port WrAddr, input, ADDR_W bits: write address.
REQ-008 The block SHALL have port WrData, input, WIDTH bits: write data.
REQ-009 The block SHALL have port WrStrb, input, WIDTH/8 bits: byte-lane write enables; bit i covers WrData[8i+7:8i].
REQ-010 The block SHALL have ports RdEnA and RdEnB, input, 1 bit each: read requests, port A and port B.
REQ-011 The block SHALL have ports RdAddrA and RdAddrB, input, ADDR_W bits each: read addresses.
REQ-012 The block SHALL have ports RdDataA and RdDataB, output, WIDTH bits each: registered read data.
REQ-013 The block SHALL have ports RdValidA and RdValidB, output, 1 bit each: read-data-valid pulses.
REQ-014 The block SHALL have port ClrReq, input, 1 bit: request to clear all entries to zero.
REQ-015 The block SHALL have port Busy, output, 1 bit: clear sweep in progress.

Function
REQ-016 When WrEn=1 and Busy=0, the entry at WrAddr SHALL take WrData at the next edge, on the byte lanes with WrStrb=1 only; other lanes SHALL keep their value.
REQ-017 A write with WrStrb all zero SHALL leave storage unchanged.
REQ-018 When RdEnx=1 and Busy=0, RdDatax SHALL be the entry at RdAddrx after the next edge, and RdValidx SHALL be 1 for exactly that cycle (1-cycle latency).
REQ-019 When RdEnx=0, RdDatax SHALL hold its last value and RdValidx SHALL be 0.
REQ-020 Ports A and B SHALL be independent; both ports may read the same or different addresses in the same cycle.
REQ-021 An address >= DEPTH SHALL drop the write; a read of such an address SHALL return 0 with RdValidx=1.
REQ-022 A read and a write to the same address in the same cycle SHALL follow REQ-034/REQ-035.
REQ-023 The clear FSM SHALL have two states: IDLE and CLEAR.
REQ-024 In IDLE with ClrReq=1, the FSM SHALL enter CLEAR, set Busy=1 at the next edge, and reset the sweep index to 0.
REQ-025 In CLEAR, the FSM SHALL zero one entry per cycle at indices 0..DEPTH-1; after zeroing index DEPTH-1 it SHALL return to IDLE with Busy=0.
REQ-026 Busy SHALL therefore be high for exactly DEPTH cycles.
REQ-027 In CLEAR, the FSM SHALL ignore WrEn, RdEnA, RdEnB and ClrReq; RdValidA and RdValidB SHALL be 0, and RdDataA and RdDataB SHALL hold their values.
REQ-028 A write and a ClrReq in the same cycle in IDLE SHALL perform the write; the sweep SHALL then zero that entry.

Reset
REQ-029 While RST=0, all DEPTH entries SHALL be 0, and RdDataA and RdDataB SHALL be 0.
REQ-030 While RST=0, RdValidA, RdValidB and Busy SHALL be 0, the FSM SHALL be IDLE, and the sweep index SHALL be 0.
REQ-031 Assertion of RST in the middle of a clear sweep SHALL abort the sweep immediately.
REQ-032 After reset deassertion, the first edge SHALL accept requests normally.

Configuration
REQ-033 The block SHALL use macro RF_WRITE_BYPASS_EN to select same-address read/write behaviour.
REQ-034 With RF_WRITE_BYPASS_EN defined, a read of an address being written in the same cycle SHALL return the new data on strobed lanes and the old data on unstrobed lanes.
REQ-035 Without RF_WRITE_BYPASS_EN, a read of an address being written in the same cycle SHALL return the old (pre-write) data.

Verification
REQ-036 After reset, read A addr 0..7 -> RdDataA=0 each, with RdValidA one cycle after each RdEnA.
REQ-037 Write addr 3 data 16'hA5C3 with strobe 2'b11, then write addr 3 data 16'hFFFF with strobe 2'b01, then read B addr 3 -> RdDataB=16'hA5FF.
REQ-038 Same cycle: write addr 5 data 16'h1234 with strobe 2'b11 and read A addr 5 (old value 0) -> RdDataA=16'h1234 with the bypass macro, 16'h0000 without; a following read -> 16'h1234.
REQ-039 Fill all entries, then pulse ClrReq -> Busy=1 for 8 cycles, and a WrEn to addr 2 during Busy is ignored; reads of all entries afterwards -> 0.
REQ-040 Assert RST during the 4th cycle of a sweep -> Busy=0 immediately and all entries 0.
REQ-041 With DEPTH=6 and ADDR_W=3, write addr 7, then read addr 7 -> RdValid=1 with data 0, and entries 0..5 unchanged.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two-read / one-write register file with byte-lane write
// strobes, registered 1-cycle reads and a one-entry-per-cycle clear sweep.
// Optional macro RF_WRITE_BYPASS_EN: a same-cycle read of the address being
// written returns the new data on strobed lanes; otherwise it returns the old data.
module reg_file_2r1w #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WrEn,
    input  logic [ADDR_W-1:0]   WrAddr,
    input  logic [WIDTH-1:0]    WrData,
    input  logic [WIDTH/8-1:0]  WrStrb,
    input  logic                RdEnA,
    input  logic [ADDR_W-1:0]   RdAddrA,
    input  logic                RdEnB,
    input  logic [ADDR_W-1:0]   RdAddrB,
    output logic [WIDTH-1:0]    RdDataA,
    output logic [WIDTH-1:0]    RdDataB,
    output logic                RdValidA,
    output logic                RdValidB,
    input  logic                ClrReq,
    output logic                Busy
);

    localparam int unsigned LANES = WIDTH / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              idle_c;
    logic              wr_go_c;
    logic [WIDTH-1:0]  wmask_c;
    logic [WIDTH-1:0]  rd_a_c;
    logic [WIDTH-1:0]  rd_b_c;

    assign idle_c  = (state == IDLE);
    assign wr_go_c = WrEn && idle_c && (32'(WrAddr) < DEPTH);

    // Expand byte strobes into a per-bit write mask
    always_comb begin
        wmask_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            wmask_c[8*l +: 8] = {8{WrStrb[l]}};
        end
    end

    // Clear FSM next-state: sweep index walks 0..DEPTH-1 while in CLEAR
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (ClrReq) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                end
            end
            CLEAR: begin
                if (idx == ADDR_W'(DEPTH - 1)) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + ADDR_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    // FSM state, sweep index and Busy flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            idx   <= '0;
            Busy  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            Busy  <= (state_nx == CLEAR);
        end
    end

    // Storage: sweep zeroing has priority; writes merge strobed lanes only
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (!idle_c && (idx == ADDR_W'(e))) begin
                    mem[e] <= '0;
                end else if (wr_go_c && (WrAddr == ADDR_W'(e))) begin
                    mem[e] <= (mem[e] & ~wmask_c) | (WrData & wmask_c);
                end
            end
        end
    end

    // Read muxes; out-of-range addresses read as zero
    always_comb begin
        rd_a_c = '0;
        rd_b_c = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (RdAddrA == ADDR_W'(e)) rd_a_c = mem[e];
            if (RdAddrB == ADDR_W'(e)) rd_b_c = mem[e];
        end
`ifdef RF_WRITE_BYPASS_EN
        if (wr_go_c && (WrAddr == RdAddrA)) rd_a_c = (rd_a_c & ~wmask_c) | (WrData & wmask_c);
        if (wr_go_c && (WrAddr == RdAddrB)) rd_b_c = (rd_b_c & ~wmask_c) | (WrData & wmask_c);
`endif
    end

    // Registered read ports; data holds when not reading or during a sweep
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RdDataA  <= '0;
            RdDataB  <= '0;
            RdValidA <= 1'b0;
            RdValidB <= 1'b0;
        end else begin
            RdValidA <= RdEnA && idle_c;
            RdValidB <= RdEnB && idle_c;
            if (RdEnA && idle_c) RdDataA <= rd_a_c;
            if (RdEnB && idle_c) RdDataB <= rd_b_c;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: table-driven vectors on a default-size
// instance plus sequences for clear sweep, reset mid-sweep and a DEPTH=6 instance.
module tb_reg_file_2r1w;

    logic        CLK;
    logic        RST;
    logic        WrEn, RdEnA, RdEnB, ClrReq;
    logic [2:0]  WrAddr, RdAddrA, RdAddrB;
    logic [15:0] WrData;
    logic [1:0]  WrStrb;
    logic [15:0] RdDataA, RdDataB;
    logic        RdValidA, RdValidB, Busy;

    logic        d1_we, d1_ea, d1_eb, d1_clr;
    logic [2:0]  d1_wa, d1_aa, d1_ab;
    logic [15:0] d1_wd;
    logic [1:0]  d1_ws;
    logic [15:0] d1_da, d1_db;
    logic        d1_va, d1_vb, d1_busy;

    int checks = 0;
    int errors = 0;

    reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrStrb(WrStrb),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .RdDataA(RdDataA), .RdDataB(RdDataB), .RdValidA(RdValidA), .RdValidB(RdValidB),
        .ClrReq(ClrReq), .Busy(Busy)
    );

    reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) dut6 (
        .CLK(CLK), .RST(RST),
        .WrEn(d1_we), .WrAddr(d1_wa), .WrData(d1_wd), .WrStrb(d1_ws),
        .RdEnA(d1_ea), .RdAddrA(d1_aa), .RdEnB(d1_eb), .RdAddrB(d1_ab),
        .RdDataA(d1_da), .RdDataB(d1_db), .RdValidA(d1_va), .RdValidB(d1_vb),
        .ClrReq(d1_clr), .Busy(d1_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [1:0]  ws;
        logic        ea;
        logic [2:0]  aa;
        logic        eb;
        logic [2:0]  ab;
        logic        xva;
        logic [15:0] xda;
        logic        xvb;
        logic [15:0] xdb;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic [1:0] ws, input logic ea, input logic [2:0] aa,
                                input logic eb, input logic [2:0] ab, input logic xva,
                                input logic [15:0] xda, input logic xvb, input logic [15:0] xdb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ws = ws;
        v.ea = ea; v.aa = aa; v.eb = eb; v.ab = ab;
        v.xva = xva; v.xda = xda; v.xvb = xvb; v.xdb = xdb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        WrEn = 1'b0; WrAddr = '0; WrData = '0; WrStrb = '0;
        RdEnA = 1'b0; RdAddrA = '0; RdEnB = 1'b0; RdAddrB = '0; ClrReq = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        idle_in();
        WrEn = 1'b1; WrAddr = a; WrData = d; WrStrb = 2'b11;
        tick();
        idle_in();
    endtask

    task automatic rd_a(input string nm, input logic [2:0] a, input logic [15:0] exp);
        idle_in();
        RdEnA = 1'b1; RdAddrA = a;
        tick();
        chk({nm, "_valid"}, 32'(RdValidA), 32'd1);
        chk({nm, "_data"}, 32'(RdDataA), 32'(exp));
        idle_in();
    endtask

    task automatic d1_idle();
        d1_we = 1'b0; d1_wa = '0; d1_wd = '0; d1_ws = '0;
        d1_ea = 1'b0; d1_aa = '0; d1_eb = 1'b0; d1_ab = '0; d1_clr = 1'b0;
    endtask

    initial begin
        int n;
        logic bad_valid, bad_hold;
        logic [15:0] byp;

        idle_in();
        d1_idle();
        RST = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_rdA", 32'(RdDataA), 32'd0);
        chk("rst_rdB", 32'(RdDataB), 32'd0);
        chk("rst_vA", 32'(RdValidA), 32'd0);
        chk("rst_vB", 32'(RdValidB), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        RST = 1'b1;

`ifdef RF_WRITE_BYPASS_EN
        byp = 16'h1234;
`else
        byp = 16'h0000;
`endif
        for (int i = 0; i < 8; i++) begin
            vt[i] = mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b0, 3'd0, 1'b1, 16'h0, 1'b0, 16'h0);
        end
        vt[8]  = mk(1'b1, 3'd3, 16'hA5C3, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0,    1'b0, 16'h0);
        vt[9]  = mk(1'b1, 3'd3, 16'hFFFF, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0,    1'b0, 16'h0);
        vt[10] = mk(1'b0, 3'd0, 16'h0,    2'b00, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 16'h0,    1'b1, 16'hA5FF);
        vt[11] = mk(1'b1, 3'd5, 16'h1234, 2'b11, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, byp,      1'b0, 16'hA5FF);
        vt[12] = mk(1'b0, 3'd0, 16'h0,    2'b00, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 16'h1234, 1'b1, 16'h1234);
        vt[13] = mk(1'b1, 3'd1, 16'hFFFF, 2'b00, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 16'h0,    1'b0, 16'h1234);
        vt[14] = mk(1'b0, 3'd0, 16'h0,    2'b00, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 16'hA5FF, 1'b1, 16'h0);
        vt[15] = mk(1'b1, 3'd6, 16'hBEEF, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'hA5FF, 1'b0, 16'h0);
        vt[16] = mk(1'b0, 3'd0, 16'h0,    2'b00, 1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 16'hBE00, 1'b0, 16'h0);

        foreach (vt[i]) begin
            WrEn = vt[i].we; WrAddr = vt[i].wa; WrData = vt[i].wd; WrStrb = vt[i].ws;
            RdEnA = vt[i].ea; RdAddrA = vt[i].aa; RdEnB = vt[i].eb; RdAddrB = vt[i].ab;
            ClrReq = 1'b0;
            tick();
            chk($sformatf("v%0d_vA", i), 32'(RdValidA), 32'(vt[i].xva));
            chk($sformatf("v%0d_dA", i), 32'(RdDataA), 32'(vt[i].xda));
            chk($sformatf("v%0d_vB", i), 32'(RdValidB), 32'(vt[i].xvb));
            chk($sformatf("v%0d_dB", i), 32'(RdDataB), 32'(vt[i].xdb));
            chk($sformatf("v%0d_busy", i), 32'(Busy), 32'd0);
        end
        idle_in();

        // Fill, then clear with a same-cycle write; requests during sweep ignored
        for (int e = 0; e < 8; e++) wr(3'(e), 16'h1100 + 16'(e));
        WrEn = 1'b1; WrAddr = 3'd0; WrData = 16'hDEAD; WrStrb = 2'b11; ClrReq = 1'b1;
        tick();
        chk("clr_busy_rise", 32'(Busy), 32'd1);
        WrEn = 1'b1; WrAddr = 3'd2; WrData = 16'hFFFF; WrStrb = 2'b11; ClrReq = 1'b1;
        RdEnA = 1'b1; RdAddrA = 3'd2; RdEnB = 1'b1; RdAddrB = 3'd4;
        n = 0;
        bad_valid = 1'b0;
        bad_hold = 1'b0;
        while (Busy && n < 20) begin
            n++;
            tick();
            if (RdValidA || RdValidB) bad_valid = 1'b1;
            if (RdDataA !== 16'hBE00 || RdDataB !== 16'h0) bad_hold = 1'b1;
        end
        idle_in();
        chk("clr_busy_cycles", 32'(n), 32'd8);
        chk("clr_no_valid", 32'(bad_valid), 32'd0);
        chk("clr_hold_data", 32'(bad_hold), 32'd0);
        for (int e = 0; e < 8; e++) rd_a($sformatf("clr_rd%0d", e), 3'(e), 16'h0);

        // Reset during the 4th sweep cycle
        wr(3'd4, 16'h5555);
        wr(3'd7, 16'h7777);
        rd_a("pre_rst_rd7", 3'd7, 16'h7777);
        ClrReq = 1'b1;
        tick();
        ClrReq = 1'b0;
        chk("rst_sweep_busy", 32'(Busy), 32'd1);
        tick();
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst_abort_busy", 32'(Busy), 32'd0);
        chk("rst_abort_rdA", 32'(RdDataA), 32'd0);
        #1;
        RST = 1'b1;
        for (int e = 0; e < 8; e++) rd_a($sformatf("post_rst_rd%0d", e), 3'(e), 16'h0);

        // DEPTH=6 instance: out-of-range write dropped, read returns 0 with valid
        for (int e = 0; e < 6; e++) begin
            d1_idle();
            d1_we = 1'b1; d1_wa = 3'(e); d1_wd = 16'h6000 + 16'(e); d1_ws = 2'b11;
            tick();
        end
        d1_idle();
        d1_we = 1'b1; d1_wa = 3'd7; d1_wd = 16'hFFFF; d1_ws = 2'b11;
        d1_eb = 1'b1; d1_ab = 3'd5;
        tick();
        chk("d6_rdB5", 32'(d1_db), 32'h6005);
        d1_idle();
        d1_eb = 1'b1; d1_ab = 3'd7;
        tick();
        chk("d6_rd7_valid", 32'(d1_vb), 32'd1);
        chk("d6_rd7_data", 32'(d1_db), 32'd0);
        for (int e = 0; e < 6; e++) begin
            d1_idle();
            d1_ea = 1'b1; d1_aa = 3'(e);
            tick();
            chk($sformatf("d6_rd%0d", e), 32'(d1_da), 32'(16'h6000 + 16'(e)));
        end
        d1_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
